// File: rtl/matrix_input_ctrl.sv
// Input session controller: captures matrix dimensions over a byte stream and
// writes elements row-major into a buffer. Optional generator: MATRIX_RAND_GEN_EN.
module matrix_input_ctrl #(
  parameter int MAX_DIM     = 5,
  parameter int ELEM_MAX    = 9,
  parameter int TIMEOUT_CYC = 50_000_000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       gen_mode,
  input  logic [7:0] rx_data,
  input  logic       rx_valid,
  output logic       wr_en,
  output logic [4:0] wr_addr,
  output logic [7:0] wr_data,
  output logic [2:0] m_dim,
  output logic [2:0] n_dim,
  output logic       busy,
  output logic       done,
  output logic       err
);

  localparam int TMR_W = $clog2(TIMEOUT_CYC + 1);

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_GET_M    = 3'd1,
    S_GET_N    = 3'd2,
    S_GET_ELEM = 3'd3,
    S_GEN      = 3'd4,
    S_DONE     = 3'd5,
    S_ERR      = 3'd6
  } state_t;

  state_t           state_reg;
  state_t           state_next;

  logic [2:0]       m_dim_reg;
  logic [2:0]       n_dim_reg;
  logic [2:0]       row_reg;
  logic [2:0]       col_reg;
  logic [5:0]       elem_cnt_reg;
  logic [TMR_W-1:0] tmr_reg;
  logic             wr_en_reg;
  logic [4:0]       wr_addr_reg;
  logic [7:0]       wr_data_reg;

  logic             start_ok;
  logic             dim_ok;
  logic             elem_full;
  logic             timeout_hit;
  logic             waiting;
  logic [5:0]       elem_total;
  logic [4:0]       cur_addr;
  logic             wr_fire;
  logic [7:0]       wr_value;
  logic [7:0]       rx_clamped;

`ifdef MATRIX_RAND_GEN_EN
  logic             gen_reg;
  logic [7:0]       lfsr_reg;
  logic [7:0]       lfsr_next;
  logic [7:0]       lfsr_elem;

  // Fibonacci LFSR for x^8+x^6+x^5+x^4+1, shifting toward the MSB.
  assign lfsr_next[0] = lfsr_reg[7] ^ lfsr_reg[5] ^ lfsr_reg[4] ^ lfsr_reg[3];
  generate
    for (genvar gi = 1; gi < 8; gi++) begin : g_lfsr_shift
      assign lfsr_next[gi] = lfsr_reg[gi-1];
    end
  endgenerate

  assign lfsr_elem = lfsr_reg % 8'(ELEM_MAX + 1);

  always_ff @(posedge clk) begin
    if (rst) begin
      lfsr_reg <= 8'h01;
    end else begin
      lfsr_reg <= lfsr_next;
    end
  end
`else
  logic gen_mode_unused;
  assign gen_mode_unused = gen_mode;
`endif

  assign start_ok    = start && (state_reg == S_IDLE || state_reg == S_DONE ||
                                 state_reg == S_ERR);
  assign dim_ok      = (rx_data >= 8'd1) && (rx_data <= 8'(MAX_DIM));
  assign elem_total  = 6'(m_dim_reg) * 6'(n_dim_reg);
  assign elem_full   = (elem_cnt_reg == elem_total);
  assign waiting     = (state_reg == S_GET_M) || (state_reg == S_GET_N) ||
                       (state_reg == S_GET_ELEM);
  assign timeout_hit = !rx_valid && (tmr_reg >= TMR_W'(TIMEOUT_CYC - 1));
  assign cur_addr    = 5'(row_reg) * 5'(MAX_DIM) + 5'(col_reg);
  assign rx_clamped  = (rx_data <= 8'(ELEM_MAX)) ? rx_data : 8'd0;

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= S_IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // Next-state logic
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      S_IDLE: begin
        if (start) state_next = S_GET_M;
      end
      S_DONE: begin
        state_next = start ? S_GET_M : S_IDLE;
      end
      S_ERR: begin
        if (start) state_next = S_GET_M;
      end
      S_GET_M: begin
        if (rx_valid)         state_next = dim_ok ? S_GET_N : S_ERR;
        else if (timeout_hit) state_next = S_ERR;
      end
      S_GET_N: begin
        if (rx_valid) begin
          if (!dim_ok) begin
            state_next = S_ERR;
          end else begin
`ifdef MATRIX_RAND_GEN_EN
            state_next = gen_reg ? S_GEN : S_GET_ELEM;
`else
            state_next = S_GET_ELEM;
`endif
          end
        end else if (timeout_hit) begin
          state_next = S_ERR;
        end
      end
      S_GET_ELEM: begin
        // elem_full becomes true the cycle the last write is on the bus,
        // so DONE follows the last wr_en by exactly one cycle.
        if (elem_full)        state_next = S_DONE;
        else if (timeout_hit) state_next = S_ERR;
      end
`ifdef MATRIX_RAND_GEN_EN
      S_GEN: begin
        if (elem_full) state_next = S_DONE;
      end
`endif
      default: state_next = S_IDLE;
    endcase
  end

  // Status outputs decoded from the current state
  always_comb begin
    busy = 1'b0;
    done = 1'b0;
    err  = 1'b0;
    case (state_reg)
      S_GET_M, S_GET_N, S_GET_ELEM, S_GEN: busy = 1'b1;
      S_DONE:                              done = 1'b1;
      S_ERR:                               err  = 1'b1;
      default: ;
    endcase
  end

  // Element write source selection
  always_comb begin
    wr_fire  = 1'b0;
    wr_value = 8'd0;
    if (state_reg == S_GET_ELEM && rx_valid && !elem_full) begin
      wr_fire  = 1'b1;
      wr_value = rx_clamped;
    end
`ifdef MATRIX_RAND_GEN_EN
    if (state_reg == S_GEN && !elem_full) begin
      wr_fire  = 1'b1;
      wr_value = lfsr_elem;
    end
`endif
  end

  // Session datapath: dimensions, position counters, idle timer, write port
  always_ff @(posedge clk) begin
    if (rst) begin
      m_dim_reg    <= 3'd0;
      n_dim_reg    <= 3'd0;
      row_reg      <= 3'd0;
      col_reg      <= 3'd0;
      elem_cnt_reg <= 6'd0;
      tmr_reg      <= '0;
      wr_en_reg    <= 1'b0;
      wr_addr_reg  <= 5'd0;
      wr_data_reg  <= 8'd0;
`ifdef MATRIX_RAND_GEN_EN
      gen_reg      <= 1'b0;
`endif
    end else begin
      wr_en_reg <= 1'b0;
      if (start_ok) begin
        row_reg      <= 3'd0;
        col_reg      <= 3'd0;
        elem_cnt_reg <= 6'd0;
        tmr_reg      <= '0;
`ifdef MATRIX_RAND_GEN_EN
        gen_reg      <= gen_mode;
`endif
      end else begin
        if (waiting) begin
          tmr_reg <= rx_valid ? '0 : tmr_reg + TMR_W'(1);
        end
        if (state_reg == S_GET_M && rx_valid && dim_ok) begin
          m_dim_reg <= rx_data[2:0];
        end
        if (state_reg == S_GET_N && rx_valid && dim_ok) begin
          n_dim_reg <= rx_data[2:0];
        end
        if (wr_fire) begin
          wr_en_reg    <= 1'b1;
          wr_addr_reg  <= cur_addr;
          wr_data_reg  <= wr_value;
          elem_cnt_reg <= elem_cnt_reg + 6'd1;
          if (col_reg == n_dim_reg - 3'd1) begin
            col_reg <= 3'd0;
            row_reg <= row_reg + 3'd1;
          end else begin
            col_reg <= col_reg + 3'd1;
          end
        end
      end
    end
  end

  assign wr_en   = wr_en_reg;
  assign wr_addr = wr_addr_reg;
  assign wr_data = wr_data_reg;
  assign m_dim   = m_dim_reg;
  assign n_dim   = n_dim_reg;

endmodule

// File: tb/tb_matrix_input_ctrl.sv
// Self-checking bench for matrix_input_ctrl: session-level model feeding a
// cycle-stamped write/done scoreboard, plus literal per-scenario expectations.
module tb_matrix_input_ctrl;

  localparam int MAXD = 5;
  localparam int EMAX = 9;
  localparam int TO   = 100;
`ifdef MATRIX_RAND_GEN_EN
  localparam bit GEN_EN = 1'b1;
`else
  localparam bit GEN_EN = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0;
  logic       gen_mode = 1'b0;
  logic [7:0] rx_data = 8'd0;
  logic       rx_valid = 1'b0;
  logic       wr_en;
  logic [4:0] wr_addr;
  logic [7:0] wr_data;
  logic [2:0] m_dim;
  logic [2:0] n_dim;
  logic       busy;
  logic       done;
  logic       err;

  matrix_input_ctrl #(.MAX_DIM(MAXD), .ELEM_MAX(EMAX), .TIMEOUT_CYC(TO)) dut (
    .clk(clk), .rst(rst), .start(start), .gen_mode(gen_mode),
    .rx_data(rx_data), .rx_valid(rx_valid),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .m_dim(m_dim), .n_dim(n_dim), .busy(busy), .done(done), .err(err)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int errors = 0;
  int checks = 0;
  bit chk_en = 1'b0;

  typedef struct { int cyc; int addr; int data; } wr_t;
  wr_t wq[$];
  int  dq[$];
  int  log_addr[$];
  int  log_data[$];
  int  done_cnt = 0;

  // Session model: 0 not receiving, 1 wants m, 2 wants n, 3 elements
  int ph = 0, mm = 0, nn = 0, kk = 0;
  bit gm = 1'b0;

  int t35_addr[6] = '{0, 1, 2, 5, 6, 7};
  int t35_data[6] = '{1, 2, 3, 4, 5, 6};
  int t28_addr[4] = '{0, 1, 5, 6};
  int t28_data[4] = '{3, 9, 0, 0};

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic m_start(input bit g);
    if (ph == 0) begin
      ph = 1; gm = g; kk = 0;
    end
  endtask

  // c is the cycle on which a write caused by this byte must be visible
  task automatic m_rx(input int b, input int c);
    case (ph)
      1: begin
        if (b >= 1 && b <= MAXD) begin mm = b; ph = 2; end
        else ph = 0;
      end
      2: begin
        if (b >= 1 && b <= MAXD) begin
          nn = b;
          if (gm && GEN_EN) begin
            for (int i = 0; i < mm * nn; i++)
              wq.push_back(wr_t'{c + 1 + i, (i / nn) * MAXD + (i % nn), -1});
            dq.push_back(c + 1 + mm * nn);
            ph = 0;
          end else begin
            ph = 3;
          end
        end else begin
          ph = 0;
        end
      end
      3: begin
        wq.push_back(wr_t'{c, (kk / nn) * MAXD + (kk % nn), (b <= EMAX) ? b : 0});
        kk++;
        if (kk == mm * nn) begin
          dq.push_back(c + 1);
          ph = 0;
        end
      end
      default: ;
    endcase
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic send(input int b);
    rx_data = 8'(b);
    rx_valid = 1'b1;
    m_rx(b, cyc + 1);
    $display("rx   byte=%0d cycle=%0d", b, cyc);
    tick(1);
    rx_valid = 1'b0;
  endtask

  task automatic go(input bit g);
    start = 1'b1;
    gen_mode = g;
    m_start(g);
    $display("start gen_mode=%0d cycle=%0d", g, cyc);
    tick(1);
    start = 1'b0;
    gen_mode = 1'b0;
  endtask

  task automatic clr();
    log_addr.delete();
    log_data.delete();
    done_cnt = 0;
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_wr_en"}, int'(wr_en), 0);
    chk({tag, "_wr_addr"}, int'(wr_addr), 0);
    chk({tag, "_wr_data"}, int'(wr_data), 0);
    chk({tag, "_m_dim"}, int'(m_dim), 0);
    chk({tag, "_n_dim"}, int'(n_dim), 0);
    chk({tag, "_busy"}, int'(busy), 0);
    chk({tag, "_done"}, int'(done), 0);
    chk({tag, "_err"}, int'(err), 0);
  endtask

  // Per-cycle scoreboard of the write port and the done pulse
  bit exp_we, exp_dn;
  always @(negedge clk) begin
    if (chk_en) begin
      while (wq.size() > 0 && wq[0].cyc < cyc) begin
        checks++; errors++;
        $display("FAIL wr_missing: got none expected addr %0d at cycle %0d", wq[0].addr, wq[0].cyc);
        void'(wq.pop_front());
      end
      while (dq.size() > 0 && dq[0] < cyc) begin
        checks++; errors++;
        $display("FAIL done_missing: got none expected pulse at cycle %0d", dq[0]);
        void'(dq.pop_front());
      end
      exp_we = (wq.size() > 0) && (wq[0].cyc == cyc);
      chk("wr_en", int'(wr_en), int'(exp_we));
      if (wr_en) begin
        log_addr.push_back(int'(wr_addr));
        log_data.push_back(int'(wr_data));
        $display("wr   addr=%0d data=%0d cycle=%0d", wr_addr, wr_data, cyc);
      end
      if (exp_we) begin
        if (wr_en) begin
          chk("wr_addr", int'(wr_addr), wq[0].addr);
          if (wq[0].data < 0) chk("wr_data_range", int'(wr_data <= 8'(EMAX)), 1);
          else                chk("wr_data", int'(wr_data), wq[0].data);
        end
        void'(wq.pop_front());
      end
      exp_dn = (dq.size() > 0) && (dq[0] == cyc);
      chk("done", int'(done), int'(exp_dn));
      if (exp_dn) void'(dq.pop_front());
      if (done) done_cnt++;
    end
  end

  initial begin
    tick(3);
    chk_reset_outputs("reset");
    chk_en = 1'b1;
    rst = 1'b0;
    tick(2);

    // 2x3 receive session
    clr();
    go(1'b0);
    send(2); send(3);
    for (int i = 1; i <= 6; i++) send(i);
    tick(3);
    chk("t35_nwr", log_addr.size(), 6);
    for (int i = 0; i < 6; i++) begin
      chk("t35_addr", log_addr[i], t35_addr[i]);
      chk("t35_data", log_data[i], t35_data[i]);
    end
    chk("t35_m_dim", int'(m_dim), 2);
    chk("t35_n_dim", int'(n_dim), 3);
    chk("t35_done_cnt", done_cnt, 1);
    chk("t35_err", int'(err), 0);
    chk("t35_busy", int'(busy), 0);

    // Out-of-range element becomes zero
    clr();
    go(1'b0);
    send(1); send(1); send(12);
    tick(3);
    chk("t36_nwr", log_addr.size(), 1);
    chk("t36_addr", log_addr[0], 0);
    chk("t36_data", log_data[0], 0);
    chk("t36_done_cnt", done_cnt, 1);
    chk("t36_err", int'(err), 0);

    // Bad dimension, then recovery via start
    clr();
    go(1'b0);
    send(6);
    tick(2);
    chk("t37_err", int'(err), 1);
    chk("t37_busy", int'(busy), 0);
    go(1'b0);
    chk("t37_err_clear", int'(err), 0);
    chk("t37_busy_again", int'(busy), 1);
    send(1); send(1); send(7);
    tick(3);
    chk("t37_nwr", log_addr.size(), 1);
    chk("t37_addr", log_addr[0], 0);
    chk("t37_data", log_data[0], 7);
    chk("t37_done_cnt", done_cnt, 1);

    // start+rx together, start while busy, clamping, col wrap, stray byte
    clr();
    start = 1'b1; rx_valid = 1'b1; rx_data = 8'd2;
    m_start(1'b0);
    tick(1);
    start = 1'b0; rx_valid = 1'b0;
    send(2);
    go(1'b0);
    send(2);
    send(3); tick(2);
    send(9); send(10); send(0);
    tick(3);
    send(4);
    tick(2);
    chk("t28_nwr", log_addr.size(), 4);
    for (int i = 0; i < 4; i++) begin
      chk("t28_addr", log_addr[i], t28_addr[i]);
      chk("t28_data", log_data[i], t28_data[i]);
    end
    chk("t28_m_dim", int'(m_dim), 2);
    chk("t28_n_dim", int'(n_dim), 2);
    chk("t28_done_cnt", done_cnt, 1);

    // Idle timeout inside element phase
    clr();
    go(1'b0);
    send(2); send(2); send(1);
    tick(TO - 10);
    chk("t38_err_early", int'(err), 0);
    chk("t38_busy_early", int'(busy), 1);
    tick(15);
    ph = 0;
    chk("t38_err", int'(err), 1);
    send(3);
    tick(2);
    chk("t38_nwr", log_addr.size(), 1);
    chk("t38_err_hold", int'(err), 1);
    chk("t38_done_cnt", done_cnt, 0);

    // Reset mid-session
    clr();
    go(1'b0);
    send(3); send(3); send(1); send(2); send(3);
    rst = 1'b1;
    ph = 0;
    tick(1);
    chk_reset_outputs("t39");
    rst = 1'b0;
    send(4); send(5);
    tick(3);
    chk("t39_nwr", log_addr.size(), 3);
    chk("t39_done_cnt", done_cnt, 0);

`ifdef MATRIX_RAND_GEN_EN
    // Generated 5x5 matrix; bytes during generation are ignored
    clr();
    go(1'b1);
    send(5); send(5);
    send(7); send(8);
    tick(30);
    chk("t40_nwr", log_addr.size(), 25);
    for (int i = 0; i < 25; i++) chk("t40_addr", log_addr[i], i);
    chk("t40_done_cnt", done_cnt, 1);
    chk("t40_err", int'(err), 0);
`else
    // gen_mode has no effect without the generator
    clr();
    go(1'b1);
    send(1); send(2); send(4); send(12);
    tick(3);
    chk("gm_nwr", log_addr.size(), 2);
    chk("gm_addr1", log_addr[1], 1);
    chk("gm_data0", log_data[0], 4);
    chk("gm_data1", log_data[1], 0);
    chk("gm_done_cnt", done_cnt, 1);
`endif

    tick(2);
    chk("wq_drained", wq.size(), 0);
    chk("dq_drained", dq.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/matrix_input_ctrl.md
MATRIX_INPUT_CTRL -- requirements
Module: matrix_input_ctrl

Interface
REQ-001 SHALL have parameter MAX_DIM, default 5, maximum row/column count.
REQ-002 SHALL have parameter ELEM_MAX, default 9, largest legal element value.
REQ-003 SHALL have parameter TIMEOUT_CYC, default 50_000_000, idle cycles allowed between received bytes.
REQ-004 SHALL have port clk  input  1  system clock; all logic on rising edge.
REQ-005 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-006 SHALL have port start  input  1  one-cycle request from controller FSM to begin an input session.
REQ-007 SHALL have port gen_mode  input  1  sampled with start: 1 = generate elements, 0 = receive elements.
REQ-008 SHALL have port rx_data  input  8  received UART byte, raw binary value.
REQ-009 SHALL have port rx_valid  input  1  one-cycle strobe qualifying rx_data.
REQ-010 SHALL have port wr_en  output  1  matrix buffer write strobe.
REQ-011 SHALL have port wr_addr  output  5  element address = row*MAX_DIM + col.
REQ-012 SHALL have port wr_data  output  8  element value.
REQ-013 SHALL have port m_dim  output  3  captured row count.
REQ-014 SHALL have port n_dim  output  3  captured column count.
REQ-015 SHALL have port busy  output  1  high in GET_M, GET_N, GET_ELEM, GEN.
REQ-016 SHALL have port done  output  1  one-cycle pulse on session completion.
REQ-017 SHALL have port err  output  1  high while in ERR.

Function
REQ-018 SHALL implement states IDLE, GET_M, GET_N, GET_ELEM, GEN, DONE, ERR.
REQ-019 SHALL move IDLE, DONE or ERR -> GET_M on start, latching gen_mode and clearing element counter; start in any busy state is ignored.
REQ-020 GET_M: on rx_valid with 1 <= rx_data <= MAX_DIM latch m_dim, go GET_N; any other value -> ERR.
REQ-021 GET_N: same rule for n_dim; valid -> GET_ELEM (gen_mode latched 0) or GEN (gen_mode latched 1, RAND_GEN_EN only).
REQ-022 GET_ELEM: each rx_valid produces wr_en high exactly one cycle later, wr_data = rx_data if rx_data <= ELEM_MAX else 0 (no error).
REQ-023 Element order SHALL be row-major; col wraps at n_dim-1 to 0 with row+1.
REQ-024 After write of element (m_dim-1, n_dim-1) SHALL enter DONE; done high exactly one cycle, the cycle after the last wr_en; DONE -> IDLE next cycle.
REQ-025 rx_valid in IDLE, DONE, ERR or GEN SHALL be ignored.
REQ-026 Timeout counter SHALL clear on entering GET_M and on every rx_valid; reaching TIMEOUT_CYC in GET_M/GET_N/GET_ELEM -> ERR.
REQ-027 ERR SHALL hold until start or rst; no wr_en in ERR.
REQ-028 start and rx_valid in same cycle from IDLE/DONE/ERR: start wins, byte discarded.
REQ-029 wr_en SHALL never assert outside GET_ELEM/GEN write cycles; wr_addr never exceeds MAX_DIM*MAX_DIM-1.

Reset
REQ-030 rst SHALL force IDLE, wr_en=0, wr_addr=0, wr_data=0, m_dim=0, n_dim=0, busy=0, done=0, err=0, counters=0, LFSR=8'h01.
REQ-031 rst mid-session SHALL abort with no further writes; rst has priority over start.

Configuration
REQ-032 Macro MATRIX_RAND_GEN_EN SHALL compile in GEN state and 8-bit LFSR (x^8+x^6+x^5+x^4+1, advanced every clock).
REQ-033 With MATRIX_RAND_GEN_EN: GEN writes one element per cycle, wr_data = lfsr mod (ELEM_MAX+1), m_dim*n_dim writes, then DONE.
REQ-034 Without MATRIX_RAND_GEN_EN: gen_mode port remains but is ignored; GET_N always proceeds to GET_ELEM; no LFSR logic.

Verification
REQ-035 start, bytes 2,3,1,2,3,4,5,6 -> six writes addr 0,1,2,5,6,7 data 1..6, m_dim=2, n_dim=3, done pulse one cycle after last write.
REQ-036 start, bytes 1,1,12 -> single write addr 0 data 0, done pulse, err=0.
REQ-037 start, byte 6 (MAX_DIM=5) -> err=1, no writes; then start, bytes 1,1,7 -> err clears, write addr 0 data 7.
REQ-038 TIMEOUT_CYC=100: start, bytes 2,2,1, then silence 100 cycles -> err=1, exactly one write issued.
REQ-039 rst asserted after 3rd element of 3x3 session -> all outputs to reset values next cycle, no further wr_en.
REQ-040 MATRIX_RAND_GEN_EN, gen_mode=1, start, bytes 5,5 -> 25 consecutive writes addr 0..24, all data <= 9, done pulse, later rx bytes ignored.
